// File: rtl/pad_attr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pad_attr_seq_ctrl
// Function : Shadow/active pad attribute registers with a config port and a
//            commit sequencer. PAD_ATTR_SEQ_STAGGER_EN selects staggered
//            per-pad loading; otherwise all pads load together.
// Revision : 1.0 - initial release
// ============================================================================
module pad_attr_seq_ctrl #(
  parameter int                 NPADS      = 8,
  parameter int                 PADATTR    = 16,
  parameter int                 STAGGER    = 4,
  parameter logic [PADATTR-1:0] RESET_ATTR = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cfg_req_i,
  output logic                       cfg_gnt_o,
  input  logic                       cfg_we_i,
  input  logic [$clog2(NPADS)-1:0]   cfg_idx_i,
  input  logic [PADATTR-1:0]         cfg_wdata_i,
  output logic [PADATTR-1:0]         cfg_rdata_o,
  output logic                       cfg_rvalid_o,
  input  logic                       commit_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [NPADS*PADATTR-1:0]   pad_attributes_o
);

  localparam int IDXW = $clog2(NPADS);

  logic [PADATTR-1:0] shadow_q [NPADS];
  logic [PADATTR-1:0] active_q [NPADS];
  logic               busy_q;
  logic               done_q;
  logic               rvalid_q;
  logic [PADATTR-1:0] rdata_q;
  logic [PADATTR-1:0] rd_mux;
  logic               wr_en;
  logic [NPADS-1:0]   load_en;

  // Reads are always accepted; writes stall while a sequence owns the shadows.
  assign cfg_gnt_o = cfg_req_i & (~cfg_we_i | ~busy_q);
  assign wr_en     = cfg_gnt_o & cfg_we_i;

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NPADS; k++) begin
      if (cfg_idx_i == IDXW'(k)) rd_mux = shadow_q[k];
    end
  end

`ifdef PAD_ATTR_SEQ_STAGGER_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int                GAPW     = (STAGGER > 2) ? $clog2(STAGGER - 1) : 1;
  localparam logic [GAPW-1:0]   GAP_INIT = GAPW'((STAGGER > 2) ? STAGGER - 2 : 0);
  localparam logic [IDXW-1:0]   LAST_PAD = IDXW'(NPADS - 1);

  state_e            state_q;
  logic [IDXW-1:0]   cnt_q;
  logic [GAPW-1:0]   gap_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (commit_i) begin
            state_q <= APPLY;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        APPLY: begin
          if (cnt_q == LAST_PAD) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (STAGGER == 1) begin
              state_q <= APPLY;
            end else begin
              state_q <= GAP;
              gap_q   <= GAP_INIT;
            end
          end
        end
        GAP: begin
          // gap_q counts the remaining idle cycles before the next pad load
          if (gap_q == '0) state_q <= APPLY;
          else             gap_q   <= gap_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    load_en = '0;
    for (int k = 0; k < NPADS; k++) begin
      load_en[k] = (state_q == APPLY) && (cnt_q == IDXW'(k));
    end
  end
`else
  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_e;

  state_e state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (commit_i) begin
            state_q <= APPLY;
            busy_q  <= 1'b1;
          end
        end
        APPLY: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_en = {NPADS{state_q == APPLY}};
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NPADS; k++) begin
        shadow_q[k] <= RESET_ATTR;
        active_q[k] <= RESET_ATTR;
      end
    end else begin
      for (int k = 0; k < NPADS; k++) begin
        if (wr_en && (cfg_idx_i == IDXW'(k))) shadow_q[k] <= cfg_wdata_i;
        if (load_en[k])                       active_q[k] <= shadow_q[k];
      end
    end
  end

  // Out-of-range indices match no pad, so they write nothing and read zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= cfg_gnt_o;
      rdata_q  <= (cfg_gnt_o && !cfg_we_i) ? rd_mux : '0;
    end
  end

  generate
    for (genvar k = 0; k < NPADS; k++) begin : g_out
      assign pad_attributes_o[k*PADATTR +: PADATTR] = active_q[k];
    end
  endgenerate

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign cfg_rvalid_o = rvalid_q;
  assign cfg_rdata_o  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_pad_attr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pad_attr_seq_ctrl
// Function : Directed self-checking bench for pad_attr_seq_ctrl; expectations
//            follow PAD_ATTR_SEQ_STAGGER_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pad_attr_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NPADS=8
  logic         req = 0, we = 0, commit = 0;
  logic [2:0]   idx = '0;
  logic [15:0]  wdata = '0;
  logic         gnt, rvalid, busy, done;
  logic [15:0]  rdata;
  logic [127:0] pads;

  // Instance B: NPADS=5 so out-of-range indices exist
  logic         b_req = 0, b_we = 0, b_commit = 0;
  logic [2:0]   b_idx = '0;
  logic [15:0]  b_wdata = '0;
  logic         b_gnt, b_rvalid, b_busy, b_done;
  logic [15:0]  b_rdata;
  logic [79:0]  b_pads;

  int n_cmp = 0;
  int n_err = 0;

  pad_attr_seq_ctrl #(.NPADS(8), .PADATTR(16), .STAGGER(4), .RESET_ATTR(16'h0000)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_req_i(req), .cfg_gnt_o(gnt), .cfg_we_i(we),
    .cfg_idx_i(idx), .cfg_wdata_i(wdata), .cfg_rdata_o(rdata), .cfg_rvalid_o(rvalid),
    .commit_i(commit), .busy_o(busy), .done_o(done), .pad_attributes_o(pads)
  );

  pad_attr_seq_ctrl #(.NPADS(5), .PADATTR(16), .STAGGER(4), .RESET_ATTR(16'h0000)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .cfg_req_i(b_req), .cfg_gnt_o(b_gnt), .cfg_we_i(b_we),
    .cfg_idx_i(b_idx), .cfg_wdata_i(b_wdata), .cfg_rdata_o(b_rdata), .cfg_rvalid_o(b_rvalid),
    .commit_i(b_commit), .busy_o(b_busy), .done_o(b_done), .pad_attributes_o(b_pads)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] i, input logic [15:0] d, output logic g);
    req = 1; we = 1; idx = i; wdata = d;
    #1 g = gnt;
    step();
    req = 0; we = 0;
  endtask

  task automatic do_read(input logic [2:0] i, output logic g, output logic v, output logic [15:0] d);
    req = 1; we = 0; idx = i;
    #1 g = gnt;
    step();
    req = 0;
    v = rvalid; d = rdata;
  endtask

  function automatic logic [127:0] base_pads();
    logic [127:0] e;
    for (int k = 0; k < 8; k++) e[k*16 +: 16] = 16'h1000 + 16'(k);
    return e;
  endfunction

  task automatic test_reset();
    step(); step();
    n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0)   begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
    n_cmp++; if (rdata !== 16'h0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    n_cmp++; if (pads !== 128'h0) begin n_err++; $display("FAIL reset_pads got=%h exp=0", pads); end
    #3 rst_n = 1;
    step();
  endtask

  task automatic test_read_after_reset();
    req = 1; we = 0; idx = 3;
    #1;
    n_cmp++; if (gnt !== 1'b1) begin n_err++; $display("FAIL rd3_gnt got=%b exp=1", gnt); end
    step();
    req = 0;
    n_cmp++; if (rvalid !== 1'b1)  begin n_err++; $display("FAIL rd3_rvalid got=%b exp=1", rvalid); end
    n_cmp++; if (rdata !== 16'h0)  begin n_err++; $display("FAIL rd3_rdata got=%h exp=0", rdata); end
    n_cmp++; if (pads !== 128'h0)  begin n_err++; $display("FAIL rd3_pads got=%h exp=0", pads); end
    step();
    n_cmp++; if (rvalid !== 1'b0)  begin n_err++; $display("FAIL rd3_rvalid_drop got=%b exp=0", rvalid); end
  endtask

  task automatic test_write_shadow();
    logic g, v;
    logic [15:0] d;
    for (int k = 0; k < 8; k++) begin
      do_write(3'(k), 16'h1000 + 16'(k), g);
      n_cmp++; if (g !== 1'b1) begin n_err++; $display("FAIL wr_gnt idx=%0d got=%b exp=1", k, g); end
      n_cmp++; if (rvalid !== 1'b1 || rdata !== 16'h0)
        begin n_err++; $display("FAIL wr_resp idx=%0d got=%b/%h exp=1/0000", k, rvalid, rdata); end
    end
    do_read(3'd5, g, v, d);
    n_cmp++; if (d !== 16'h1005) begin n_err++; $display("FAIL rd5_shadow got=%h exp=1005", d); end
    n_cmp++; if (pads !== 128'h0) begin n_err++; $display("FAIL pads_before_commit got=%h exp=0", pads); end
  endtask

  task automatic test_commit();
    logic [127:0] e;
    commit = 1;
    step();
    commit = 0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL commit_busy_E0 got=%b exp=1", busy); end
`ifdef PAD_ATTR_SEQ_STAGGER_EN
    for (int n = 1; n <= 29; n++) begin
      step();
      e = '0;
      for (int k = 0; k < 8; k++) if (n >= 1 + 4*k) e[k*16 +: 16] = 16'h1000 + 16'(k);
      n_cmp++; if (pads !== e) begin n_err++; $display("FAIL stag_pads n=%0d got=%h exp=%h", n, pads, e); end
      n_cmp++; if (busy !== (n < 29)) begin n_err++; $display("FAIL stag_busy n=%0d got=%b exp=%b", n, busy, (n < 29)); end
      n_cmp++; if (done !== (n == 29)) begin n_err++; $display("FAIL stag_done n=%0d got=%b exp=%b", n, done, (n == 29)); end
    end
`else
    n_cmp++; if (pads !== 128'h0) begin n_err++; $display("FAIL flat_pads_E0 got=%h exp=0", pads); end
    n_cmp++; if (done !== 1'b0)   begin n_err++; $display("FAIL flat_done_E0 got=%b exp=0", done); end
    step();
    e = base_pads();
    n_cmp++; if (pads !== e)    begin n_err++; $display("FAIL flat_pads_E1 got=%h exp=%h", pads, e); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flat_busy_E1 got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL flat_done_E1 got=%b exp=1", done); end
`endif
    step();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_single got=%b exp=0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_blocked_write();
    logic g, v;
    logic [15:0] d;
    commit = 1;
    step();
    commit = 0;
`ifdef PAD_ATTR_SEQ_STAGGER_EN
    begin
      int dones;
      logic got;
      dones = 0; got = 0;
      req = 1; we = 1; idx = 2; wdata = 16'hABCD;
      for (int m = 0; m < 40; m++) begin
        #1;
        n_cmp++; if (gnt !== (m >= 29)) begin n_err++; $display("FAIL blk_gnt m=%0d got=%b exp=%b", m, gnt, (m >= 29)); end
        got = gnt;
        commit = (m == 10);
        step();
        commit = 0;
        n_cmp++; if (done !== (m + 1 == 29)) begin n_err++; $display("FAIL blk_done m=%0d got=%b exp=%b", m, done, (m + 1 == 29)); end
        if (done) dones++;
        if (got) break;
      end
      req = 0; we = 0;
      n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL blk_grant_timeout got=%b exp=1", got); end
      n_cmp++; if (dones != 1)   begin n_err++; $display("FAIL blk_done_count got=%0d exp=1", dones); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL blk_commit_ignored got=%b exp=0", busy); end
    end
`else
    req = 1; we = 1; idx = 2; wdata = 16'hABCD; commit = 1;
    #1;
    n_cmp++; if (gnt !== 1'b0)  begin n_err++; $display("FAIL blk_gnt_busy got=%b exp=0", gnt); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL blk_busy got=%b exp=1", busy); end
    step();
    commit = 0;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL blk_done got=%b exp=1", done); end
    #1;
    n_cmp++; if (gnt !== 1'b1)  begin n_err++; $display("FAIL blk_gnt_idle got=%b exp=1", gnt); end
    step();
    req = 0; we = 0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0)
      begin n_err++; $display("FAIL blk_commit_ignored got=%b/%b exp=0/0", busy, done); end
    n_cmp++; if (rvalid !== 1'b1 || rdata !== 16'h0)
      begin n_err++; $display("FAIL blk_wr_resp got=%b/%h exp=1/0000", rvalid, rdata); end
`endif
    do_read(3'd2, g, v, d);
    n_cmp++; if (d !== 16'hABCD) begin n_err++; $display("FAIL blk_rd2 got=%h exp=abcd", d); end
    n_cmp++; if (pads[32 +: 16] !== 16'h1002) begin n_err++; $display("FAIL blk_pad2_active got=%h exp=1002", pads[32 +: 16]); end
  endtask

  task automatic test_same_cycle();
    int b;
    req = 1; we = 1; idx = 0; wdata = 16'h5A5A; commit = 1;
    #1;
    n_cmp++; if (gnt !== 1'b1) begin n_err++; $display("FAIL same_gnt got=%b exp=1", gnt); end
    step();
    req = 0; we = 0; commit = 0;
    step();
    n_cmp++; if (pads[15:0] !== 16'h5A5A) begin n_err++; $display("FAIL same_pad0 got=%h exp=5a5a", pads[15:0]); end
    b = 0;
    while (busy && b < 50) begin step(); b++; end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL same_finish got=%b exp=0", busy); end
    n_cmp++; if (pads[32 +: 16] !== 16'hABCD) begin n_err++; $display("FAIL same_pad2 got=%h exp=abcd", pads[32 +: 16]); end
    step();
  endtask

  task automatic test_out_of_range();
    int b;
    b_req = 1; b_we = 1; b_idx = 6; b_wdata = 16'hFFFF;
    #1;
    n_cmp++; if (b_gnt !== 1'b1) begin n_err++; $display("FAIL oor_wr_gnt got=%b exp=1", b_gnt); end
    step();
    b_idx = 4; b_wdata = 16'h1234;
    n_cmp++; if (b_rvalid !== 1'b1 || b_rdata !== 16'h0)
      begin n_err++; $display("FAIL oor_wr_resp got=%b/%h exp=1/0000", b_rvalid, b_rdata); end
    step();
    b_we = 0; b_idx = 6;
    #1;
    n_cmp++; if (b_gnt !== 1'b1) begin n_err++; $display("FAIL oor_rd_gnt got=%b exp=1", b_gnt); end
    step();
    b_idx = 4;
    n_cmp++; if (b_rvalid !== 1'b1 || b_rdata !== 16'h0)
      begin n_err++; $display("FAIL oor_rd6 got=%b/%h exp=1/0000", b_rvalid, b_rdata); end
    step();
    b_idx = 1;
    n_cmp++; if (b_rdata !== 16'h1234) begin n_err++; $display("FAIL oor_rd4 got=%h exp=1234", b_rdata); end
    step();
    b_req = 0;
    n_cmp++; if (b_rdata !== 16'h0) begin n_err++; $display("FAIL oor_rd1 got=%h exp=0", b_rdata); end
    b_commit = 1;
    step();
    b_commit = 0;
    b = 0;
    while (b_busy && b < 50) begin step(); b++; end
    n_cmp++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL oor_seq_timeout got=%b exp=0", b_busy); end
    n_cmp++; if (b_pads !== {16'h1234, 64'h0}) begin n_err++; $display("FAIL oor_pads got=%h exp=%h", b_pads, {16'h1234, 64'h0}); end
    step();
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    commit = 1;
    step();
    commit = 0;
`ifdef PAD_ATTR_SEQ_STAGGER_EN
    for (int n = 1; n <= 10; n++) step();
    n_cmp++; if (pads[47:0] !== {16'hABCD, 16'h1001, 16'h5A5A})
      begin n_err++; $display("FAIL mid_pre_pads got=%h exp=abcd10015a5a", pads[47:0]); end
    n_cmp++; if (pads[63:48] !== 16'h1003) begin n_err++; $display("FAIL mid_pad3_old got=%h exp=1003", pads[63:48]); end
`endif
    rst_n = 0;
    #1;
    n_cmp++; if (pads !== 128'h0) begin n_err++; $display("FAIL mid_pads_reset got=%h exp=0", pads); end
    n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL mid_busy got=%b exp=0", busy); end
    #2 rst_n = 1;
    saw_done = 0;
    for (int n = 0; n < 35; n++) begin step(); if (done) saw_done = 1; end
    n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL mid_no_done got=%b exp=0", saw_done); end
    n_cmp++; if (pads !== 128'h0)   begin n_err++; $display("FAIL mid_pads_stay got=%h exp=0", pads); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_after_reset();
    test_write_shadow();
    test_commit();
    test_blocked_write();
    test_same_cycle();
    test_out_of_range();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
